// File: rtl/cart_mapper_pkg.sv
// Shared types and constants for the banked cartridge mapper.
package cart_mapper_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0]  REG_NIBBLE    = 4'hF;
   localparam logic [2:0]  SRAM_CTL_IDX  = 3'd0;
   localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

endpackage

// File: rtl/cart_bank_mapper_if.sv
// Memory-controller handshake between the mapper and the SDRAM arbiter.
interface cart_bank_mapper_if #(
   parameter int unsigned MEM_AW = 24
) ();

   logic [MEM_AW-2:0] MEM_A;
   logic              MEM_SRAM;
   logic [15:0]       MEM_DO;
   logic [15:0]       MEM_DI;
   logic              MEM_REQ;
   logic              MEM_WE;
   logic [1:0]        MEM_BE;
   logic              MEM_ACK;

   modport master (
      output MEM_A, MEM_SRAM, MEM_DO, MEM_REQ, MEM_WE, MEM_BE,
      input  MEM_DI, MEM_ACK
   );

   modport slave (
      input  MEM_A, MEM_SRAM, MEM_DO, MEM_REQ, MEM_WE, MEM_BE,
      output MEM_DI, MEM_ACK
   );

endinterface

// File: rtl/cart_bank_regs.sv
// Bank/SRAM-control register file: TIME-window write decode, readback and slot->bank lookup.
module cart_bank_regs
   import cart_mapper_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned BANK_W    = 6
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         lwr_n,
   input  logic                         time_n,
   input  logic [3:0]                   reg_nib,
   input  logic [2:0]                   reg_idx,
   input  logic [BANK_W-1:0]            vdi,
   input  logic [$clog2(NUM_SLOTS)-1:0] slot,
   output logic                         sen,
   output logic                         wp,
   output logic                         time_hit,
   output logic [7:0]                   rd_data,
   output logic [BANK_W-1:0]            slot_bank
);

   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);

   logic              lwr_q;
   logic              idx_ok;
   logic              wr_en;
   logic [SLOT_W-1:0] widx;
   logic [BANK_W-1:0] bank [NUM_SLOTS];

   assign time_hit  = !time_n && (reg_nib == REG_NIBBLE);
   assign idx_ok    = 32'(reg_idx) < NUM_SLOTS;
   assign widx      = reg_idx[SLOT_W-1:0];
   assign wr_en     = time_hit && idx_ok && lwr_q && !lwr_n;
   assign slot_bank = bank[slot];

   // Index 0 is SRAM control, so slot 0 is never rewritten and stays on bank 0.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         lwr_q <= 1'b1;
         sen   <= 1'b0;
         wp    <= 1'b0;
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            bank[SLOT_W'(i)] <= BANK_W'(i);
         end
      end else begin
         lwr_q <= lwr_n;
         if (wr_en) begin
            if (reg_idx == SRAM_CTL_IDX) begin
               sen <= vdi[0];
               wp  <= vdi[1];
            end else begin
               bank[widx] <= vdi;
            end
         end
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (idx_ok) begin
         if (reg_idx == SRAM_CTL_IDX) rd_data = {6'b0, wp, sen};
         else                         rd_data = 8'(bank[widx]);
      end
   end

endmodule

// File: rtl/cart_bank_mapper.sv
// Banked cartridge mapper: slot/SRAM address translation and registered request/DTACK handshake.
module cart_bank_mapper
   import cart_mapper_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 8,
   parameter int unsigned BANK_W    = 6,
   parameter int unsigned MEM_AW    = 24,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [23:1]         VA,
   input  logic [15:0]         VDI,
   output logic [15:0]         VDO,
   input  logic                AS_N,
   input  logic                CE0_N,
   input  logic                CAS0_N,
   input  logic                LWR_N,
   input  logic                UWR_N,
   input  logic                TIME_N,
   output logic                DTACK_N,
   input  logic [23:0]         sram_sz,
   cart_bank_mapper_if.master  mem
);

   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
   localparam int unsigned OFF_W  = 21 - SLOT_W;
   localparam int unsigned MA_W   = MEM_AW - 1;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              abort, abort_nxt;
   logic              dtack_n_q, dtack_n_nxt;
   logic              req_q, req_nxt;
   logic              we_q, we_nxt;
   logic              sram_q, sram_nxt;
   logic [1:0]        be_q, be_nxt;
   logic [MA_W-1:0]   a_q, a_nxt;
   logic [15:0]       do_q, do_nxt;
   logic [15:0]       vdo_q, vdo_nxt;

   logic              as_d1, as_d2, as_fall;
   logic              sen, wp, time_hit;
   logic [7:0]        rd_data;
   logic [BANK_W-1:0] slot_bank;
   logic              wr, sram_hit, start, drop, done;
   logic [23:0]       sram_b;
   logic [MA_W-1:0]   acc_a;
   logic              unused_ok;

   cart_bank_regs #(
      .NUM_SLOTS (NUM_SLOTS),
      .BANK_W    (BANK_W)
   ) u_regs (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .lwr_n     (LWR_N),
      .time_n    (TIME_N),
      .reg_nib   (VA[7:4]),
      .reg_idx   (VA[3:1]),
      .vdi       (VDI[BANK_W-1:0]),
      .slot      (VA[21 -: SLOT_W]),
      .sen       (sen),
      .wp        (wp),
      .time_hit  (time_hit),
      .rd_data   (rd_data),
      .slot_bank (slot_bank)
   );

   // AS_N is asynchronous to CLK; a two-stage history gives both sync and edge detect.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         as_d1 <= 1'b1;
         as_d2 <= 1'b1;
      end else begin
         as_d1 <= AS_N;
         as_d2 <= as_d1;
      end
   end

   assign as_fall  = as_d2 && !as_d1;
   assign wr       = !LWR_N || !UWR_N;
   assign sram_hit = sen && (sram_sz != 24'd0) && VA[21] && !CE0_N;
   assign start    = as_fall && !CE0_N && (!CAS0_N || wr);
   assign drop     = wr && (!sram_hit || wp);
   assign done     = mem.MEM_ACK || (cnt == CNT_W'(TIMEOUT));
   assign sram_b   = 24'({VA[21:1], 1'b0}) & (sram_sz - 24'd1);
   assign acc_a    = sram_hit ? MA_W'(sram_b[23:1]) : MA_W'({slot_bank, VA[OFF_W:1]});
   assign unused_ok = ^{VA[23:22], sram_b[0]};

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state     <= S_IDLE;
         cnt       <= '0;
         abort     <= 1'b0;
         dtack_n_q <= 1'b1;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         sram_q    <= 1'b0;
         be_q      <= 2'b00;
         a_q       <= '0;
         do_q      <= 16'h0000;
         vdo_q     <= 16'h0000;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         abort     <= abort_nxt;
         dtack_n_q <= dtack_n_nxt;
         req_q     <= req_nxt;
         we_q      <= we_nxt;
         sram_q    <= sram_nxt;
         be_q      <= be_nxt;
         a_q       <= a_nxt;
         do_q      <= do_nxt;
         vdo_q     <= vdo_nxt;
      end
   end

   // A bus cycle abandoned during REQ still waits for the memory, then skips DONE.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = '0;
      abort_nxt   = abort;
      dtack_n_nxt = 1'b1;
      req_nxt     = req_q;
      we_nxt      = we_q;
      sram_nxt    = sram_q;
      be_nxt      = be_q;
      a_nxt       = a_q;
      do_nxt      = do_q;
      vdo_nxt     = vdo_q;

      if (time_hit) vdo_nxt = {8'h00, rd_data};

      case (state)
         S_IDLE: begin
            if (start) begin
               if (drop) begin
                  state_nxt   = S_DONE;
                  dtack_n_nxt = 1'b0;
               end else begin
                  state_nxt = S_REQ;
                  req_nxt   = 1'b1;
                  cnt_nxt   = CNT_W'(1);
                  abort_nxt = 1'b0;
                  a_nxt     = acc_a;
                  sram_nxt  = sram_hit;
                  we_nxt    = wr;
                  be_nxt    = wr ? {!UWR_N, !LWR_N} : 2'b11;
                  do_nxt    = VDI;
               end
            end
         end
         S_REQ: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (as_d1) abort_nxt = 1'b1;
            if (done) begin
               req_nxt = 1'b0;
               vdo_nxt = mem.MEM_ACK ? mem.MEM_DI : TIMEOUT_RDATA;
               if (abort || as_d1) begin
                  state_nxt = S_IDLE;
               end else begin
                  state_nxt   = S_DONE;
                  dtack_n_nxt = 1'b0;
               end
            end
         end
         S_DONE: begin
            if (as_d1) state_nxt   = S_IDLE;
            else       dtack_n_nxt = 1'b0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign VDO          = vdo_q;
   assign DTACK_N      = dtack_n_q;
   assign mem.MEM_A    = a_q;
   assign mem.MEM_SRAM = sram_q;
   assign mem.MEM_DO   = do_q;
   assign mem.MEM_REQ  = req_q;
   assign mem.MEM_WE   = we_q;
   assign mem.MEM_BE   = be_q;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed checks of cart_bank_mapper: banking, SRAM protect, timeout, reset and abandoned cycles.
module tb_cart_bank_mapper;

   localparam int TO = 255;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [23:1] va;
   logic [15:0] vdi;
   logic [15:0] vdo;
   logic        as_n, ce0_n, cas0_n, lwr_n, uwr_n, time_n;
   logic        dtack_n;
   logic [23:0] sram_sz;

   int n_checks = 0;
   int n_fail   = 0;

   cart_bank_mapper_if #(.MEM_AW(24)) mem_if ();

   cart_bank_mapper #(
      .NUM_SLOTS (8),
      .BANK_W    (6),
      .MEM_AW    (24),
      .TIMEOUT   (TO)
   ) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .VA      (va),
      .VDI     (vdi),
      .VDO     (vdo),
      .AS_N    (as_n),
      .CE0_N   (ce0_n),
      .CAS0_N  (cas0_n),
      .LWR_N   (lwr_n),
      .UWR_N   (uwr_n),
      .TIME_N  (time_n),
      .DTACK_N (dtack_n),
      .sram_sz (sram_sz),
      .mem     (mem_if)
   );

   always #5 CLK = ~CLK;

   task automatic tick;
      @(negedge CLK);
   endtask

   task automatic reg_write(input logic [23:0] ba, input logic [15:0] d);
      va = ba[23:1]; vdi = d; time_n = 1'b0;
      tick;
      lwr_n = 1'b0;
      tick;
      lwr_n = 1'b1; time_n = 1'b1;
      tick;
   endtask

   task automatic time_read(input logic [23:0] ba, output logic [15:0] v);
      va = ba[23:1]; time_n = 1'b0;
      tick;
      v = vdo;
      time_n = 1'b1;
      tick;
   endtask

   task automatic bus_start(input logic [23:0] ba, input logic is_wr, input logic [15:0] d);
      va = ba[23:1]; vdi = d; time_n = 1'b1; ce0_n = 1'b0;
      if (is_wr) begin lwr_n = 1'b0; uwr_n = 1'b0; end
      else       cas0_n = 1'b0;
      as_n = 1'b0;
   endtask

   task automatic bus_release;
      as_n = 1'b1; ce0_n = 1'b1; cas0_n = 1'b1; lwr_n = 1'b1; uwr_n = 1'b1;
   endtask

   task automatic ack(input logic [15:0] d);
      mem_if.MEM_ACK = 1'b1; mem_if.MEM_DI = d;
      tick;
      mem_if.MEM_ACK = 1'b0;
   endtask

   task automatic test_reset;
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL reset_dtack: got %b expected 1", dtack_n); end
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mem_if.MEM_REQ); end
      n_checks++; if (vdo !== 16'h0000) begin n_fail++; $display("FAIL reset_vdo: got %h expected 0000", vdo); end
      n_checks++; if (mem_if.MEM_A !== 23'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected 0", mem_if.MEM_A); end
      n_checks++; if ({mem_if.MEM_SRAM, mem_if.MEM_WE, mem_if.MEM_BE} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0000", {mem_if.MEM_SRAM, mem_if.MEM_WE, mem_if.MEM_BE}); end
      n_checks++; if (mem_if.MEM_DO !== 16'h0000) begin n_fail++; $display("FAIL reset_do: got %h expected 0000", mem_if.MEM_DO); end
   endtask

   task automatic test_defaults;
      logic [15:0] v;
      time_read(24'hA130F7, v);
      n_checks++; if (v !== 16'h0003) begin n_fail++; $display("FAIL default_time_rd: got %h expected 0003", v); end
      bus_start(24'h180000, 1'b0, 16'h0);
      tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL default_req_early: got %b expected 0", mem_if.MEM_REQ); end
      tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL default_req: got %b expected 1", mem_if.MEM_REQ); end
      n_checks++; if ({mem_if.MEM_A, 1'b0} !== 24'h180000) begin n_fail++; $display("FAIL default_addr: got %h expected 180000", {mem_if.MEM_A, 1'b0}); end
      ack(16'h5A5A);
      n_checks++; if (vdo !== 16'h5A5A) begin n_fail++; $display("FAIL default_vdo: got %h expected 5a5a", vdo); end
      bus_release;
      tick;
      n_checks++; if (dtack_n !== 1'b0) begin n_fail++; $display("FAIL default_dtack_hold: got %b expected 0", dtack_n); end
      tick;
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL default_dtack_release: got %b expected 1", dtack_n); end
   endtask

   task automatic test_bank_switch;
      reg_write(24'hA130F7, 16'h000A);
      bus_start(24'h180010, 1'b0, 16'h0);
      tick; tick;
      n_checks++; if ({mem_if.MEM_A, 1'b0} !== 24'h500010) begin n_fail++; $display("FAIL bank_addr: got %h expected 500010", {mem_if.MEM_A, 1'b0}); end
      n_checks++; if (mem_if.MEM_WE !== 1'b0 || mem_if.MEM_BE !== 2'b11) begin n_fail++; $display("FAIL bank_rd_ctl: got we=%b be=%b expected we=0 be=11", mem_if.MEM_WE, mem_if.MEM_BE); end
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL bank_dtack_pre: got %b expected 1", dtack_n); end
      ack(16'h1234);
      n_checks++; if (vdo !== 16'h1234) begin n_fail++; $display("FAIL bank_vdo: got %h expected 1234", vdo); end
      n_checks++; if (dtack_n !== 1'b0) begin n_fail++; $display("FAIL bank_dtack: got %b expected 0", dtack_n); end
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL bank_req_drop: got %b expected 0", mem_if.MEM_REQ); end
      bus_release;
      tick; tick;
   endtask

   task automatic test_sram_protect;
      logic [15:0] v;
      reg_write(24'hA130F1, 16'h0001);
      bus_start(24'h200002, 1'b1, 16'hBEEF);
      tick; tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL sram_req: got %b expected 1", mem_if.MEM_REQ); end
      n_checks++; if ({mem_if.MEM_SRAM, mem_if.MEM_WE, mem_if.MEM_BE} !== 4'b1111) begin n_fail++; $display("FAIL sram_ctl: got %b expected 1111", {mem_if.MEM_SRAM, mem_if.MEM_WE, mem_if.MEM_BE}); end
      n_checks++; if (mem_if.MEM_DO !== 16'hBEEF) begin n_fail++; $display("FAIL sram_do: got %h expected beef", mem_if.MEM_DO); end
      n_checks++; if ({mem_if.MEM_A, 1'b0} !== 24'h000002) begin n_fail++; $display("FAIL sram_addr: got %h expected 000002", {mem_if.MEM_A, 1'b0}); end
      ack(16'h0000);
      n_checks++; if (dtack_n !== 1'b0) begin n_fail++; $display("FAIL sram_dtack: got %b expected 0", dtack_n); end
      bus_release;
      tick; tick;
      reg_write(24'hA130F1, 16'h0003);
      time_read(24'hA130F1, v);
      n_checks++; if (v !== 16'h0003) begin n_fail++; $display("FAIL sram_ctl_rd: got %h expected 0003", v); end
      bus_start(24'h200002, 1'b1, 16'hBEEF);
      tick;
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL wp_dtack_early: got %b expected 1", dtack_n); end
      tick;
      n_checks++; if (dtack_n !== 1'b0) begin n_fail++; $display("FAIL wp_dtack: got %b expected 0", dtack_n); end
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL wp_req: got %b expected 0", mem_if.MEM_REQ); end
      bus_release;
      tick; tick;
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL wp_release: got %b expected 1", dtack_n); end
   endtask

   task automatic test_rom_write;
      bus_start(24'h001000, 1'b1, 16'h1111);
      tick; tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b0 || dtack_n !== 1'b0) begin n_fail++; $display("FAIL rom_wr: got req=%b dtack_n=%b expected req=0 dtack_n=0", mem_if.MEM_REQ, dtack_n); end
      bus_release;
      tick; tick;
   endtask

   task automatic test_timeout;
      bus_start(24'h000100, 1'b0, 16'h0);
      tick; tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL to_req: got %b expected 1", mem_if.MEM_REQ); end
      for (int i = 0; i < TO - 1; i++) tick;
      n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL to_dtack_early: got %b expected 1", dtack_n); end
      tick;
      n_checks++; if (dtack_n !== 1'b0) begin n_fail++; $display("FAIL to_dtack: got %b expected 0", dtack_n); end
      n_checks++; if (vdo !== 16'hFFFF) begin n_fail++; $display("FAIL to_vdo: got %h expected ffff", vdo); end
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL to_req_drop: got %b expected 0", mem_if.MEM_REQ); end
      bus_release;
      tick; tick;
   endtask

   task automatic test_reset_mid;
      bus_start(24'h000200, 1'b0, 16'h0);
      tick; tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req_pre: got %b expected 1", mem_if.MEM_REQ); end
      RST_N = 1'b0;
      tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b0 || dtack_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid: got req=%b dtack_n=%b expected req=0 dtack_n=1", mem_if.MEM_REQ, dtack_n); end
      RST_N = 1'b1;
      bus_release;
      ack(16'hDEAD);
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL stray_ack_dtack: got %b expected 1", dtack_n); end
         tick;
      end
   endtask

   task automatic test_early_release;
      bus_start(24'h000040, 1'b0, 16'h0);
      tick; tick;
      n_checks++; if (mem_if.MEM_REQ !== 1'b1) begin n_fail++; $display("FAIL early_req: got %b expected 1", mem_if.MEM_REQ); end
      bus_release;
      tick; tick;
      ack(16'h7777);
      n_checks++; if (mem_if.MEM_REQ !== 1'b0) begin n_fail++; $display("FAIL early_req_drop: got %b expected 0", mem_if.MEM_REQ); end
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (dtack_n !== 1'b1) begin n_fail++; $display("FAIL early_dtack: got %b expected 1", dtack_n); end
         tick;
      end
      // Banks were reset above, so slot 3 maps to bank 3 again.
      bus_start(24'h180010, 1'b0, 16'h0);
      tick; tick;
      n_checks++; if ({mem_if.MEM_A, 1'b0} !== 24'h180010) begin n_fail++; $display("FAIL next_addr: got %h expected 180010", {mem_if.MEM_A, 1'b0}); end
      ack(16'h4321);
      n_checks++; if (dtack_n !== 1'b0 || vdo !== 16'h4321) begin n_fail++; $display("FAIL next_done: got dtack_n=%b vdo=%h expected dtack_n=0 vdo=4321", dtack_n, vdo); end
      bus_release;
      tick; tick;
   endtask

   initial begin
      RST_N = 1'b0;
      va = '0; vdi = 16'h0;
      as_n = 1'b1; ce0_n = 1'b1; cas0_n = 1'b1; lwr_n = 1'b1; uwr_n = 1'b1; time_n = 1'b1;
      sram_sz = 24'h008000;
      mem_if.MEM_ACK = 1'b0; mem_if.MEM_DI = 16'h0;
      repeat (3) tick;
      RST_N = 1'b1;
      tick;

      test_reset;
      test_defaults;
      test_bank_switch;
      test_sram_protect;
      test_rom_write;
      test_timeout;
      test_reset_mid;
      test_early_release;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
